// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encodings, default
// parameter values and the address-width helper.
package fetch_sequencer_pkg;

    // Sequencer states; the numeric encoding is visible on o_state.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_e;

    localparam int unsigned SIZE_DEFAULT            = 32'd32;
    localparam int unsigned MAX_INSTRUCTION_DEFAULT = 32'd9;
    localparam int unsigned COUNT_SIZE_DEFAULT      = 32'd32;
    localparam logic [31:0] HALT_OPCODE_DEFAULT     = 32'hFFFF_FFFF;

    // Word address width for a memory of the given depth (never below 1 bit).
    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        if (depth > 32'd1) begin
            w = $clog2(depth);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fetch_sequencer_load_writer.sv
// Loader-side write port of the instruction memory. While the sequencer is
// in LOAD it accepts one word per valid cycle, registers it together with
// the current write pointer and presents it as a one-cycle write strobe.
module fetch_sequencer_load_writer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned SIZE            = SIZE_DEFAULT,
    parameter int unsigned MAX_INSTRUCTION = MAX_INSTRUCTION_DEFAULT,
    parameter int unsigned ADDR_W          = addr_width(MAX_INSTRUCTION)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_active_i,
    input  logic              load_valid_i,
    input  logic [SIZE-1:0]   load_data_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [SIZE-1:0]   mem_data_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_INSTRUCTION - 32'd1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SIZE-1:0]   data_q;
    logic              accept_s;

    // Handshake: ready for the whole LOAD state, done on the final accepted word.
    always_comb begin
        load_ready_o = load_active_i;
        accept_s     = load_active_i && load_valid_i;
        if (accept_s && (load_last_i || (ptr_q == LAST_ADDR))) begin
            load_done_o = 1'b1;
        end else begin
            load_done_o = 1'b0;
        end
    end

    // Write pointer: held at zero outside LOAD so every load starts at word 0.
    always_comb begin
        ptr_d = ptr_q;
        if (!load_active_i) begin
            ptr_d = '0;
        end else if (accept_s) begin
            ptr_d = ptr_q + ADDR_ONE;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer and registered write port; the strobe lasts exactly one cycle per word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            we_q  <= accept_s;
            if (accept_s) begin
                addr_q <= ptr_q;
                data_q <= load_data_i;
            end else begin
                addr_q <= addr_q;
                data_q <= data_q;
            end
        end
    end

    assign mem_we_o   = we_q;
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sequences load / run / single-step / halt,
// drives the fetch stall and PC-source select, owns the instruction-memory
// write port during loads and counts executed (non-stalled) fetch cycles.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned    SIZE            = SIZE_DEFAULT,
    parameter int unsigned    MAX_INSTRUCTION = MAX_INSTRUCTION_DEFAULT,
    parameter logic [SIZE-1:0] HALT_OPCODE    = SIZE'(HALT_OPCODE_DEFAULT),
    parameter int unsigned    COUNT_SIZE      = COUNT_SIZE_DEFAULT,
    localparam int unsigned   ADDR_W          = addr_width(MAX_INSTRUCTION)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_load,
    input  logic                  i_cmd_run,
    input  logic                  i_cmd_step,
    input  logic                  i_cmd_halt,
    input  logic                  i_load_valid,
    input  logic [SIZE-1:0]       i_load_data,
    input  logic                  i_load_last,
    output logic                  o_load_ready,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [SIZE-1:0]       o_mem_data,
    input  logic [SIZE-1:0]       i_instruction,
    input  logic                  i_hazard_stall,
    input  logic                  i_branch_taken,
    input  logic [SIZE-1:0]       i_branch_target,
    output logic                  o_stall,
    output logic                  o_mux_selec,
    output logic [SIZE-1:0]       o_instruction_jump,
    output logic                  o_fetch_rst,
    output logic [2:0]            o_state,
    output logic [COUNT_SIZE-1:0] o_cycle_count
);

    localparam logic [COUNT_SIZE-1:0] CNT_MAX = {COUNT_SIZE{1'b1}};
    localparam logic [COUNT_SIZE-1:0] CNT_ONE = {{(COUNT_SIZE-1){1'b0}}, 1'b1};

    state_e                state_q;
    state_e                state_d;
    logic [COUNT_SIZE-1:0] cnt_q;
    logic [COUNT_SIZE-1:0] cnt_d;
    logic                  fetch_rst_q;
    logic                  fetch_rst_d;
    logic                  load_active_s;
    logic                  load_done_s;
    logic                  exec_state_s;
    logic                  stall_s;
    logic                  fetch_s;

    assign load_active_s = (state_q == ST_LOAD);

    fetch_sequencer_load_writer #(
        .SIZE            (SIZE),
        .MAX_INSTRUCTION (MAX_INSTRUCTION),
        .ADDR_W          (ADDR_W)
    ) u_load_writer (
        .clk           (clk),
        .rst           (rst),
        .load_active_i (load_active_s),
        .load_valid_i  (i_load_valid),
        .load_data_i   (i_load_data),
        .load_last_i   (i_load_last),
        .load_ready_o  (o_load_ready),
        .load_done_o   (load_done_s),
        .mem_we_o      (o_mem_we),
        .mem_addr_o    (o_mem_addr),
        .mem_data_o    (o_mem_data)
    );

    // Stall and branch steering: fetch only moves in RUN/STEP when no hazard is pending.
    always_comb begin
        exec_state_s = (state_q == ST_RUN) || (state_q == ST_STEP);
        if (exec_state_s) begin
            stall_s = i_hazard_stall;
        end else begin
            stall_s = 1'b1;
        end
        fetch_s     = exec_state_s && !stall_s;
        o_mux_selec = fetch_s && i_branch_taken;
        if (o_mux_selec) begin
            o_instruction_jump = i_branch_target;
        end else begin
            o_instruction_jump = '0;
        end
    end

    assign o_stall = stall_s;
    assign o_state = state_q;

    // Next-state logic; commands not meaningful in the current state are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (i_cmd_load) begin
                    state_d = ST_LOAD;
                end else if (i_cmd_run) begin
                    state_d = ST_RUN;
                end else if (i_cmd_step) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (load_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                // The halt opcode only counts once it is actually fetched (not stalled).
                if (i_cmd_halt || (fetch_s && (i_instruction == HALT_OPCODE))) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                if (fetch_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Cycle counter: cleared when a load begins, saturating count of fetch cycles.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != ST_LOAD) && (state_d == ST_LOAD)) begin
            cnt_d = '0;
        end else if (fetch_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // PC reset to the fetch stage fires once as a load finishes.
    always_comb begin
        if ((state_q == ST_LOAD) && (state_d != ST_LOAD)) begin
            fetch_rst_d = 1'b1;
        end else begin
            fetch_rst_d = 1'b0;
        end
    end

    // State, counter and fetch-reset registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fetch_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fetch_rst_q <= fetch_rst_d;
        end
    end

    assign o_fetch_rst   = fetch_rst_q;
    assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table for the main
// load / run / step / branch flow, plus hand-written sequences for the
// full-depth load and the asynchronous reset during LOAD.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        i_cmd_load, i_cmd_run, i_cmd_step, i_cmd_halt;
    logic        i_load_valid;
    logic [31:0] i_load_data;
    logic        i_load_last;
    logic        o_load_ready;
    logic        o_mem_we;
    logic [3:0]  o_mem_addr;
    logic [31:0] o_mem_data;
    logic [31:0] i_instruction;
    logic        i_hazard_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        o_stall;
    logic        o_mux_selec;
    logic [31:0] o_instruction_jump;
    logic        o_fetch_rst;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_count;

    int total;
    int bad;

    fetch_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .i_cmd_load         (i_cmd_load),
        .i_cmd_run          (i_cmd_run),
        .i_cmd_step         (i_cmd_step),
        .i_cmd_halt         (i_cmd_halt),
        .i_load_valid       (i_load_valid),
        .i_load_data        (i_load_data),
        .i_load_last        (i_load_last),
        .o_load_ready       (o_load_ready),
        .o_mem_we           (o_mem_we),
        .o_mem_addr         (o_mem_addr),
        .o_mem_data         (o_mem_data),
        .i_instruction      (i_instruction),
        .i_hazard_stall     (i_hazard_stall),
        .i_branch_taken     (i_branch_taken),
        .i_branch_target    (i_branch_target),
        .o_stall            (o_stall),
        .o_mux_selec        (o_mux_selec),
        .o_instruction_jump (o_instruction_jump),
        .o_fetch_rst        (o_fetch_rst),
        .o_state            (o_state),
        .o_cycle_count      (o_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        // inputs applied for the cycle
        logic        ld, run, step, halt;
        logic        lv;
        logic [31:0] ldata;
        logic        llast;
        logic [31:0] instr;
        logic        haz, br;
        logic [31:0] tgt;
        // outputs expected during that cycle
        logic [2:0]  st;
        logic        stall, mux;
        logic [31:0] jump;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        rdy, frst;
        logic [31:0] cnt;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vec [NVEC];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        i_cmd_load = 1'b0; i_cmd_run = 1'b0; i_cmd_step = 1'b0; i_cmd_halt = 1'b0;
        i_load_valid = 1'b0; i_load_data = 32'h0; i_load_last = 1'b0;
        i_instruction = 32'h0; i_hazard_stall = 1'b0;
        i_branch_taken = 1'b0; i_branch_target = 32'h0;
    endtask

    initial begin
        logic [107:0] act_v;
        logic [107:0] exp_v;
        int           nwr;
        int           nfrst;
        logic         acc;

        total = 0;
        bad   = 0;
        drive_idle();

        //            ld    run   step  halt  lv    ldata          llast instr          haz   br    tgt            st    stall mux   jump           we    addr  wdata          rdy   frst  cnt
        vec[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,3'd0,1'b1,1'b0,32'h0000_0000,1'b0,4'd0,32'h0000_0000,1'b0,1'b0,32'd0};
        vec[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h3C01_0001,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,3'd1,1'b1,1'b0,32'h0000_0000,1'b0,4'd0,32'h0000_0000,1'b1,1'b0,32'd0};
        vec[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h3C03_0002,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,3'd1,1'b1,1'b0,32'h0000_0000,1'b1,4'd0,32'h3C01_0001,1'b1,1'b0,32'd0};
        vec[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'hFFFF_FFFF,1'b1,32'h0000_0000,1'b0,1'b0,32'h0000_0000,3'd1,1'b1,1'b0,32'h0000_0000,1'b1,4'd1,32'h3C03_0002,1'b1,1'b0,32'd0};
        vec[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,3'd0,1'b1,1'b0,32'h0000_0000,1'b1,4'd2,32'hFFFF_FFFF,1'b0,1'b1,32'd0};
        vec[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,3'd0,1'b1,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd0};
        vec[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h3C01_0001,1'b0,1'b0,32'h0000_0000,3'd2,1'b0,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd0};
        vec[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h3C03_0002,1'b0,1'b1,32'h0000_0006,3'd2,1'b0,1'b1,32'h0000_0006,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd1};
        vec[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h3C03_0002,1'b1,1'b1,32'h0000_0006,3'd2,1'b1,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd2};
        vec[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0020,1'b0,1'b0,32'h0000_0000,3'd2,1'b0,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd2};
        vec[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0024,1'b0,1'b0,32'h0000_0000,3'd2,1'b0,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd3};
        vec[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'hFFFF_FFFF,1'b1,1'b0,32'h0000_0000,3'd2,1'b1,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd4};
        vec[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'hFFFF_FFFF,1'b0,1'b0,32'h0000_0000,3'd2,1'b0,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd4};
        vec[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,3'd4,1'b1,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd5};
        vec[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b1,1'b0,32'h0000_0000,3'd3,1'b1,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd5};
        vec[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b1,1'b0,32'h0000_0000,3'd3,1'b1,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd5};
        vec[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b0,1'b1,32'h0000_0040,3'd3,1'b0,1'b1,32'h0000_0040,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd5};
        vec[17] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0000_0000,1'b0,32'hFFFF_FFFF,1'b0,1'b0,32'h0000_0000,3'd4,1'b1,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd6};
        vec[18] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,3'd4,1'b1,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd6};
        vec[19] = '{1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,3'd2,1'b0,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd6};
        vec[20] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,3'd4,1'b1,1'b0,32'h0000_0000,1'b0,4'd2,32'hFFFF_FFFF,1'b0,1'b0,32'd7};

        // Reset state.
        rst = 1'b1;
        #12;
        chk32("rst_state",     {29'd0, o_state}, 32'd0);
        chk32("rst_stall",     {31'd0, o_stall}, 32'd1);
        chk32("rst_we_rdy",    {30'd0, o_mem_we, o_load_ready}, 32'd0);
        chk32("rst_addr_data", o_mem_data | {28'd0, o_mem_addr}, 32'd0);
        chk32("rst_count",     o_cycle_count, 32'd0);
        chk32("rst_mux_frst",  {30'd0, o_mux_selec, o_fetch_rst}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven main flow.
        for (int i = 0; i < NVEC; i++) begin
            i_cmd_load = vec[i].ld;   i_cmd_run = vec[i].run;
            i_cmd_step = vec[i].step; i_cmd_halt = vec[i].halt;
            i_load_valid = vec[i].lv; i_load_data = vec[i].ldata; i_load_last = vec[i].llast;
            i_instruction = vec[i].instr; i_hazard_stall = vec[i].haz;
            i_branch_taken = vec[i].br; i_branch_target = vec[i].tgt;
            @(negedge clk);
            act_v = {o_state, o_stall, o_mux_selec, o_instruction_jump, o_mem_we, o_mem_addr,
                     o_mem_data, o_load_ready, o_fetch_rst, o_cycle_count};
            exp_v = {vec[i].st, vec[i].stall, vec[i].mux, vec[i].jump, vec[i].we, vec[i].addr,
                     vec[i].wdata, vec[i].rdy, vec[i].frst, vec[i].cnt};
            total = total + 1;
            if (act_v !== exp_v) begin
                bad = bad + 1;
                $display("FAIL vec%0d {st,stall,mux,jump,we,addr,wdata,rdy,frst,cnt}: got %h expected %h",
                         i, act_v, exp_v);
            end
            @(posedge clk);
            #1;
        end
        drive_idle();

        // Full-depth load with no last marker: nine words, then ready drops.
        i_cmd_load = 1'b1;
        @(posedge clk);
        #1;
        i_cmd_load   = 1'b0;
        i_load_valid = 1'b1;
        i_load_data  = 32'hA000_0000;
        nwr   = 0;
        nfrst = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk32("full_entry_state", {29'd0, o_state}, 32'd1);
                chk32("full_entry_count_cleared", o_cycle_count, 32'd0);
            end
            if (o_mem_we) begin
                chk32($sformatf("full_addr%0d", nwr), {28'd0, o_mem_addr}, nwr);
                chk32($sformatf("full_data%0d", nwr), o_mem_data, 32'hA000_0000 + nwr);
                nwr = nwr + 1;
            end
            if (o_fetch_rst) begin
                nfrst = nfrst + 1;
            end
            acc = o_load_ready && i_load_valid;
            @(posedge clk);
            #1;
            if (acc) begin
                i_load_data = i_load_data + 32'd1;
            end
        end
        chk32("full_write_count", nwr, 32'd9);
        chk32("full_fetch_rst_pulses", nfrst, 32'd1);
        chk32("full_exit_state", {29'd0, o_state}, 32'd0);
        chk32("full_ready_low", {31'd0, o_load_ready}, 32'd0);
        chk32("full_last_addr", {28'd0, o_mem_addr}, 32'd8);
        drive_idle();

        // Asynchronous reset two words into a load.
        i_cmd_load = 1'b1;
        @(posedge clk);
        #1;
        i_cmd_load   = 1'b0;
        i_load_valid = 1'b1;
        i_load_data  = 32'hB000_0000;
        @(posedge clk);
        #1;
        i_load_data = 32'hB000_0001;
        @(posedge clk);
        #1;
        i_load_valid = 1'b0;
        chk32("abort_pre_we_addr", {27'd0, o_mem_we, o_mem_addr}, {27'd0, 1'b1, 4'd1});
        chk32("abort_pre_state", {29'd0, o_state}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk32("abort_we_rdy", {30'd0, o_mem_we, o_load_ready}, 32'd0);
        chk32("abort_state", {29'd0, o_state}, 32'd0);
        chk32("abort_stall", {31'd0, o_stall}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk32("abort_post_state", {29'd0, o_state}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller for the instruction fetch stage. Owns the fetch stall and the PC-source select, and arbitrates the instruction memory between a debug loader (write port) and fetch (read). Sequences load, run, single-step and halt, and counts executed fetch cycles. Sits between the debug/command interface and instruction_fetch.

Parameters:
SIZE, 32, data/PC width
MAX_INSTRUCTION, 9, instruction memory depth in words; ADDR_W = $clog2(MAX_INSTRUCTION)
HALT_OPCODE, 32'hFFFFFFFF, instruction word that halts execution when fetched
COUNT_SIZE, 32, cycle counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
i_cmd_load  in  1  request memory load (level, sampled in IDLE/HALT)
i_cmd_run  in  1  request free run
i_cmd_step  in  1  request single fetch step
i_cmd_halt  in  1  request halt
i_load_valid  in  1  loader word valid
i_load_data  in  SIZE  loader word
i_load_last  in  1  marks final loader word
o_load_ready  out  1  sequencer accepts loader word
o_mem_we  out  1  instruction memory write enable
o_mem_addr  out  ADDR_W  instruction memory write address
o_mem_data  out  SIZE  instruction memory write data
i_instruction  in  SIZE  current fetched instruction (from fetch stage)
i_hazard_stall  in  1  pipeline hazard stall request
i_branch_taken  in  1  jump/branch resolved taken
i_branch_target  in  SIZE  jump target
o_stall  out  1  stall to fetch stage
o_mux_selec  out  1  PC source select (1 = jump target)
o_instruction_jump  out  SIZE  jump target to fetch stage
o_fetch_rst  out  1  synchronous PC reset pulse to fetch stage
o_state  out  3  current state encoding
o_cycle_count  out  COUNT_SIZE  count of non-stalled fetch cycles

Behaviour:
- Reset (async): state=IDLE; o_stall=1, o_mux_selec=0, o_instruction_jump=0, o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_load_ready=0, o_fetch_rst=0, o_cycle_count=0. Asserting rst mid-LOAD aborts immediately; partial writes stay in memory.
- States: IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4.
- IDLE/HALT: o_stall=1. Command priority load > run > step; i_cmd_halt ignored. Next-state transition on the next edge.
- LOAD: o_stall=1, o_load_ready=1. Word accepted on a cycle with i_load_valid && o_load_ready. Registered write: the cycle after acceptance, o_mem_we=1, o_mem_addr=write pointer, o_mem_data=word.
  - Write pointer starts at 0 on LOAD entry and increments per accepted word.
  - Exit to IDLE when the accepted word has i_load_last=1, or when the pointer reaches MAX_INSTRUCTION-1. o_load_ready drops the cycle after the last acceptance.
  - o_fetch_rst pulses for 1 cycle on LOAD exit.
  - o_cycle_count clears on LOAD entry.
- RUN: o_stall = i_hazard_stall (combinational).
  - i_cmd_halt → HALT.
  - Fetching HALT_OPCODE while not stalled → HALT. That cycle completes; o_stall=1 from the next cycle.
  - If both halt conditions occur together, the result is HALT (same outcome).
- STEP: o_stall = i_hazard_stall. Remains in STEP until one non-stalled cycle has occurred, then → HALT. Exactly one PC advance per step command.
- Branch: o_mux_selec = i_branch_taken && !o_stall && state∈{RUN,STEP}. o_instruction_jump = i_branch_target under the same condition, else 0. Zero latency (combinational).
- Memory arbitration: o_mem_we is only ever 1 in LOAD or on the cycle following the last acceptance. Fetch is stalled throughout, so fetch reads never overlap writes.
- o_cycle_count: +1 each cycle where state∈{RUN,STEP} and o_stall=0. Saturates at all-ones.
- Commands other than the valid ones for a state are ignored, including i_cmd_load in RUN/STEP.

Decomposition:
- Shared package: state encodings (IDLE..HALT), HALT_OPCODE default, ADDR_W derivation.
- One natural sub-module: load_writer (LOAD-state pointer, acceptance and registered write port).
- FSM, stall/branch muxing and counter stay in the top.

Test Plan:
- Reset, then i_cmd_load with 3 words (0x3C010001, 0x3C030002, 0xFFFFFFFF; last on word 3) → o_mem_we pulses at addr 0,1,2 with matching data. o_load_ready low after word 3, o_fetch_rst 1-cycle pulse, state=IDLE.
- Load 9 words without i_load_last → exits after addr 8 write; 10th valid not accepted.
- i_cmd_run with i_instruction stream ending in 0xFFFFFFFF at cycle 5 → o_stall=0 for 5 cycles, then 1. State=HALT, o_cycle_count=5.
- HALT + i_cmd_step with i_hazard_stall=1 for 2 cycles → stays STEP 3 cycles, single o_stall=0 cycle, returns to HALT, count+1.
- RUN, i_branch_taken=1 with target 0x6 → o_mux_selec=1 and o_instruction_jump=0x6 the same cycle. Same stimulus with i_hazard_stall=1 → o_mux_selec=0.
- rst asserted mid-LOAD after 2 words → o_mem_we, o_load_ready and state clear immediately without waiting for clk.
